// File: rtl/x_uart_tx_arb_pkg.sv
// Shared types and constants for the packet-level UART transmit arbiter.
package x_uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } sm_arb_t;

  localparam logic [7:0] P_HDR_ID_MASK = 8'h0F;

  // Index width for a requester count; never narrower than one bit.
  function automatic int f_id_w(input int p_req);
    return (p_req > 2) ? $clog2(p_req) : 1;
  endfunction

endpackage

// File: rtl/x_rr_pick.sv
// Round-robin picker: first set mask bit at or above ptr, wrapping modulo p_req.
module x_rr_pick
  import x_uart_tx_arb_pkg::*;
#(
  parameter int p_req = 4,
  parameter int IDW   = f_id_w(p_req)
) (
  input  logic [p_req-1:0] i_mask,
  input  logic [IDW-1:0]   i_ptr,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  // Explicit wrap keeps non-power-of-two requester counts in range.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= p_req) sum = sum - p_req;
    return IDW'(sum);
  endfunction

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int off = 0; off < p_req; off++) begin
      if (!o_any && i_mask[wrap_add(i_ptr, off)]) begin
        o_idx = wrap_add(i_ptr, off);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/x_uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one UART transmitter; each packet is
// preceded by a source-identifying header byte.
//
//   state | meaning
//   IDLE  | no packet; pick a round-robin winner when any requester is valid
//   HDR   | send header p_hdr_base | grant, requester data ignored
//   DATA  | forward granted requester's bytes until the byte flagged last
module x_uart_tx_arb
  import x_uart_tx_arb_pkg::*;
#(
  parameter int         p_req      = 4,
  parameter logic [7:0] p_hdr_base = 8'hA0,
  localparam int        IDW        = f_id_w(p_req)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_req-1:0]   i_req_valid,
  input  logic [8*p_req-1:0] i_req_data,
  input  logic [p_req-1:0]   i_req_last,
  output logic [p_req-1:0]   o_req_accept,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_accept,
  output logic               o_busy,
  output logic [IDW-1:0]     o_grant_id
);

  sm_arb_t        state, state_nxt;
  logic [IDW-1:0] grant, grant_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;

  x_rr_pick #(.p_req(p_req), .IDW(IDW)) u_pick (
    .i_mask (i_req_valid),
    .i_ptr  (rr_ptr),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    o_tx_valid   = 1'b0;
    o_tx_data    = 8'h00;
    o_req_accept = '0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = HDR;
        end
      end
      HDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = p_hdr_base | (8'(grant) & P_HDR_ID_MASK);
        if (i_tx_accept) state_nxt = DATA;
      end
      DATA: begin
        o_tx_valid          = i_req_valid[grant];
        o_tx_data           = i_req_data[{grant, 3'b000} +: 8];
        o_req_accept[grant] = i_tx_accept;
        if (i_tx_accept && i_req_last[grant]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (grant == IDW'(p_req - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy     = (state != IDLE);
  assign o_grant_id = grant;

endmodule

// File: tb/tb_x_uart_tx_arb.sv
// Bench for x_uart_tx_arb: per-requester byte queues plus a packet-level
// reference model, with directed scenarios followed by randomized traffic.
module tb_x_uart_tx_arb;

  localparam int NR    = 4;
  localparam int DEPTH = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_last, req_accept;
  logic [8*NR-1:0] req_data;
  logic [7:0]      tx_data;
  logic            tx_valid, tx_accept, busy;
  logic [1:0]      grant_id;

  logic [2:0]      v3, l3, a3;
  logic [23:0]     d3;
  logic [7:0]      td3;
  logic            tv3, ta3, b3;
  logic [1:0]      g3;

  always #5 clk = ~clk;

  x_uart_tx_arb #(.p_req(NR), .p_hdr_base(8'hA0)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_last   (req_last),
    .o_req_accept (req_accept),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_accept  (tx_accept),
    .o_busy       (busy),
    .o_grant_id   (grant_id)
  );

  x_uart_tx_arb #(.p_req(3), .p_hdr_base(8'hA0)) u_dut3 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (v3),
    .i_req_data   (d3),
    .i_req_last   (l3),
    .o_req_accept (a3),
    .o_tx_data    (td3),
    .o_tx_valid   (tv3),
    .i_tx_accept  (ta3),
    .o_busy       (b3),
    .o_grant_id   (g3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // requester byte queues: data, last flag, idle cycles before presenting
  logic [7:0] q_data [NR][DEPTH];
  logic       q_last [NR][DEPTH];
  int         q_gap  [NR][DEPTH];
  int         rd [NR];
  int         wr [NR];
  int         age[NR];

  // packet-level reference model
  bit m_busy, m_hdr;
  int m_grant, m_ptr;

  int uart_d, uart_cnt, stall_cyc;
  bit rand_uart, spur_en, scramble_en;
  logic [7:0] log_byte[$];
  int acc_cnt[NR];

  task automatic push(input int k, input logic [7:0] d, input logic last, input int gap);
    if (wr[k] < DEPTH) begin
      q_data[k][wr[k]] = d;
      q_last[k][wr[k]] = last;
      q_gap[k][wr[k]]  = gap;
      wr[k]++;
    end
  endtask

  function automatic bit pending(input int k);
    return rd[k] < wr[k];
  endfunction

  function automatic bit presenting(input int k);
    return pending(k) && (age[k] >= q_gap[k][rd[k]]);
  endfunction

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int k = 0; k < NR; k++) if (pending(k)) r = 1'b1;
    return r;
  endfunction

  task automatic clear_all();
    for (int k = 0; k < NR; k++) begin
      rd[k] = 0; wr[k] = 0; age[k] = 0; acc_cnt[k] = 0;
    end
    m_busy = 0; m_hdr = 0; m_grant = 0; m_ptr = 0;
  endtask

  // One clock: drive at negedge, check, run the UART model, advance the model.
  task automatic run_cycle();
    logic [NR-1:0] v;
    logic [NR-1:0] exp_acc;
    logic [7:0]    exp_data;
    bit            exp_valid;
    bit            acc;
    for (int k = 0; k < NR; k++) begin
      v[k] = presenting(k);
      req_valid[k] = v[k];
      if (v[k]) begin
        req_data[8*k +: 8] = q_data[k][rd[k]];
        req_last[k]        = q_last[k][rd[k]];
      end else begin
        req_data[8*k +: 8] = 8'($urandom);
        req_last[k]        = 1'($urandom);
      end
      if (scramble_en && m_busy && m_hdr && k == m_grant)
        req_data[8*k +: 8] = 8'($urandom);
    end
    tx_accept = 1'b0;
    #1;
    exp_valid = m_busy && (m_hdr || v[m_grant]);
    chk("tx_valid", tx_valid, exp_valid);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_grant);
    if (exp_valid) begin
      exp_data = m_hdr ? (8'hA0 | 8'(m_grant)) : q_data[m_grant][rd[m_grant]];
      chk("tx_data", tx_data, exp_data);
    end else if (!m_busy) begin
      chk("tx_data_idle", tx_data, 8'h00);
    end
    if (busy && !tx_valid) stall_cyc++;

    acc = 1'b0;
    if (tx_valid) begin
      uart_cnt++;
      if (uart_cnt >= uart_d) begin
        acc = 1'b1;
        uart_cnt = 0;
        if (rand_uart) uart_d = $urandom_range(1, 3);
      end
    end else begin
      uart_cnt = 0;
      if (spur_en && !busy && $urandom_range(0, 3) == 0) acc = 1'b1;
    end
    tx_accept = acc;
    #1;
    exp_acc = (m_busy && !m_hdr && acc) ? (NR'(1) << m_grant) : '0;
    chk("req_accept", req_accept, exp_acc);
    for (int k = 0; k < NR; k++) if (req_accept[k]) acc_cnt[k]++;
    if (acc && tx_valid) log_byte.push_back(tx_data);

    for (int k = 0; k < NR; k++) if (pending(k)) age[k]++;
    if (!m_busy) begin
      for (int i = 0; i < NR; i++) begin
        int c;
        c = (m_ptr + i) % NR;
        if (v[c]) begin
          m_grant = c; m_busy = 1; m_hdr = 1;
          break;
        end
      end
    end else if (m_hdr) begin
      if (acc) m_hdr = 0;
    end else if (acc) begin
      int g;
      g = m_grant;
      if (q_last[g][rd[g]]) begin
        m_busy = 0;
        m_ptr  = (g + 1) % NR;
      end
      rd[g]++;
      age[g] = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((any_pending() || m_busy) && n < budget) begin
      run_cycle();
      n++;
    end
    chk(tag, any_pending() || m_busy, 1'b0);
  endtask

  initial begin
    int exp_total;
    int base;
    req_valid = '0; req_data = '0; req_last = '0; tx_accept = 1'b0;
    v3 = '0; l3 = '0; d3 = '0; ta3 = 1'b0;
    rst = 1'b1;
    clear_all();
    uart_cnt = 0; uart_d = 2; rand_uart = 0; spur_en = 0; scramble_en = 0; stall_cyc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_req_accept", req_accept, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 2'd0);
    @(negedge clk);

    // round robin from reset: single-byte packets on every requester
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++) push(k, 8'($urandom), 1'b1, 0);
    log_byte.delete();
    drain("rr_drain", 400);
    chk("rr_log_size", log_byte.size(), 16);
    chk("rr_hdr0", log_byte[0], 8'hA0);
    chk("rr_hdr1", log_byte[2], 8'hA1);
    chk("rr_hdr2", log_byte[4], 8'hA2);
    chk("rr_hdr3", log_byte[6], 8'hA3);
    chk("rr_hdr4", log_byte[8], 8'hA0);

    // single packet from requester 2 with a slow UART
    log_byte.delete();
    acc_cnt[2] = 0;
    uart_d = 10;
    push(2, 8'h55, 1'b0, 0);
    push(2, 8'h33, 1'b1, 0);
    drain("single_drain", 200);
    chk("single_size", log_byte.size(), 3);
    chk("single_b0", log_byte[0], 8'hA2);
    chk("single_b1", log_byte[1], 8'h55);
    chk("single_b2", log_byte[2], 8'h33);
    chk("single_acc2", acc_cnt[2], 2);

    // mid-packet stall on requester 1 with requester 0 waiting
    log_byte.delete();
    uart_d = 2;
    push(1, 8'h10, 1'b0, 0);
    push(1, 8'h11, 1'b0, 20);
    push(1, 8'h12, 1'b1, 0);
    push(0, 8'h0A, 1'b1, 2);
    stall_cyc = 0;
    drain("stall_drain", 300);
    chk("stall_len", stall_cyc, 20);
    chk("stall_first_hdr", log_byte[0], 8'hA1);
    chk("stall_next_hdr", log_byte[4], 8'hA0);
    chk("stall_next_byte", log_byte[5], 8'h0A);

    // requester data churns while the header is on the line
    scramble_en = 1;
    uart_d = 3;
    push(2, 8'h77, 1'b1, 0);
    push(3, 8'h88, 1'b0, 0);
    push(3, 8'h99, 1'b1, 0);
    drain("hdr_iso_drain", 300);
    scramble_en = 0;

    // reset in the middle of a payload
    uart_d = 2;
    base = rd[2];
    push(2, 8'h21, 1'b0, 0);
    push(2, 8'h22, 1'b0, 0);
    push(2, 8'h23, 1'b0, 0);
    push(2, 8'h24, 1'b1, 0);
    for (int n = 0; n < 200 && !(m_busy && !m_hdr && rd[2] > base); n++) run_cycle();
    chk("mid_reached", m_busy && !m_hdr && rd[2] > base, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    req_valid = '0;
    tx_accept = 1'b0;
    uart_cnt  = 0;
    #1;
    chk("mrst_tx_valid", tx_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_grant", grant_id, 2'd0);
    chk("mrst_tx_data", tx_data, 8'h00);
    @(negedge clk);
    log_byte.delete();
    push(3, 8'h3C, 1'b1, 0);
    drain("mrst_drain", 100);
    chk("mrst_hdr", log_byte[0], 8'hA3);

    // randomized traffic
    log_byte.delete();
    rand_uart = 1;
    spur_en   = 1;
    exp_total = 0;
    for (int k = 0; k < NR; k++) begin
      for (int p = 0; p < 12; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++)
          push(k, 8'($urandom), b == len - 1,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
        exp_total += len + 1;
      end
    end
    drain("rand_drain", 20000);
    chk("rand_bytes", log_byte.size(), exp_total);
    spur_en = 0;

    // three requesters: grant to 2 then wrap to 0
    @(negedge clk);
    v3 = 3'b100; l3 = 3'b111; d3 = {8'h22, 8'h11, 8'h00}; ta3 = 1'b0;
    #1;
    chk("p3_idle_busy", b3, 1'b0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("p3_hdr_valid", tv3, 1'b1);
    chk("p3_hdr_data", td3, 8'hA2);
    chk("p3_hdr_grant", g3, 2'd2);
    ta3 = 1'b1;
    @(posedge clk); @(negedge clk);
    ta3 = 1'b0;
    #1;
    chk("p3_data", td3, 8'h22);
    ta3 = 1'b1;
    #1;
    chk("p3_accept", a3, 3'b100);
    v3 = 3'b111;
    @(posedge clk); @(negedge clk);
    ta3 = 1'b0;
    #1;
    chk("p3_gap_busy", b3, 1'b0);
    chk("p3_gap_valid", tv3, 1'b0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("p3_wrap_hdr", td3, 8'hA0);
    chk("p3_wrap_grant", g3, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
